// File: rtl/kronos_counter_bank.sv
// ---------------------------------------------------------------------------
// kronos_counter_bank : bank of staggered-carry segmented counters for CSRs
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module kronos_counter_bank #(
  parameter int EN_COUNTERS = 1,
  parameter int WIDTH       = 64,
  parameter int SEG_W       = 32,
  parameter int NCNT        = 1,
  parameter int CW          = (NCNT > 1) ? $clog2(NCNT) : 1,
  parameter int SW          = ((WIDTH / SEG_W) > 1) ? $clog2(WIDTH / SEG_W) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NCNT-1:0]       incr,
  input  logic [NCNT-1:0]       inhibit,
  input  logic                  load_en,
  input  logic [CW-1:0]         load_cnt,
  input  logic [SW-1:0]         load_seg,
  input  logic [SEG_W-1:0]      load_data,
  output logic [NCNT*WIDTH-1:0] count,
  output logic [NCNT-1:0]       count_vld,
  output logic [NCNT-1:0]       ovf
);

  localparam int NSEG = WIDTH / SEG_W;
  // Bit NSEG-1 of the carry register is the carry out of the top segment,
  // i.e. the overflow pulse; it never counts as a carry in flight.
  localparam logic [NSEG-1:0] VLD_MASK = {NSEG{1'b1}} >> 1;

  if ((SEG_W < 1) || (SEG_W > WIDTH) || ((WIDTH % SEG_W) != 0) || (NCNT < 1)) begin : g_param_err
    $error("kronos_counter_bank: WIDTH must be a multiple of SEG_W, SEG_W in 1..WIDTH, NCNT >= 1");
  end

  if (EN_COUNTERS != 0) begin : g_on
    logic        seg_ok;
    logic [31:0] load_seg_ext;

    assign load_seg_ext = 32'(load_seg);
    assign seg_ok       = (load_seg_ext < 32'(NSEG));

    for (genvar c = 0; c < NCNT; c++) begin : g_ch
      logic [NSEG-1:0][SEG_W-1:0] seg_q, seg_d;
      logic [NSEG-1:0]            cy_q, cy_d;
      logic [NSEG-1:0]            cin;
      logic                       hit;

      always_comb begin
        hit   = load_en && (load_cnt == CW'(c)) && seg_ok;
        seg_d = seg_q;
        cy_d  = '0;
        cin   = (cy_q << 1) | NSEG'(incr[c] & ~inhibit[c]);
        if (hit) begin
          for (int k = 0; k < NSEG; k++) begin
            if (load_seg == SW'(k)) begin
              seg_d[k] = load_data;
            end
          end
        end else begin
          for (int k = 0; k < NSEG; k++) begin
            if (cin[k]) begin
              seg_d[k] = seg_q[k] + SEG_W'(1);
              cy_d[k]  = &seg_q[k];
            end
          end
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          seg_q <= '0;
          cy_q  <= '0;
        end else begin
          seg_q <= seg_d;
          cy_q  <= cy_d;
        end
      end

      assign count[c*WIDTH +: WIDTH] = seg_q;
      assign count_vld[c]            = ~|(cy_q & VLD_MASK);
      assign ovf[c]                  = cy_q[NSEG-1];
    end
  end else begin : g_off
    logic unused_inputs;
    assign unused_inputs = ^{clk, rst, incr, inhibit, load_en, load_cnt, load_seg, load_data};
    assign count     = '0;
    assign count_vld = '1;
    assign ovf       = '0;
  end

endmodule

`default_nettype wire

// File: tb/tb_kronos_counter_bank.sv
// ---------------------------------------------------------------------------
// tb_kronos_counter_bank : scoreboard bench with a segment/carry reference model
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_kronos_counter_bank;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [2:0]   incr = '0;
  logic [2:0]   inhibit = '0;
  logic         load_en = 1'b0;
  logic [1:0]   load_cnt = '0;
  logic [1:0]   load_seg = '0;
  logic [15:0]  load_data = '0;
  logic         load_en_c = 1'b0;
  logic         load_cnt_c = 1'b0;
  logic         load_seg_c = 1'b0;
  logic [7:0]   load_data_c = '0;

  logic [143:0] a_count;
  logic [2:0]   a_vld, a_ovf;
  logic [15:0]  c_count;
  logic [1:0]   c_vld, c_ovf;
  logic [127:0] b_count;
  logic [1:0]   b_vld, b_ovf;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // A: 3 segments x 16 bits, 3 channels
  kronos_counter_bank #(.EN_COUNTERS(1), .WIDTH(48), .SEG_W(16), .NCNT(3)) u_a (
    .clk(clk), .rst(rst), .incr(incr), .inhibit(inhibit), .load_en(load_en),
    .load_cnt(load_cnt), .load_seg(load_seg), .load_data(load_data),
    .count(a_count), .count_vld(a_vld), .ovf(a_ovf));

  // C: single-segment counters
  kronos_counter_bank #(.EN_COUNTERS(1), .WIDTH(8), .SEG_W(8), .NCNT(2)) u_c (
    .clk(clk), .rst(rst), .incr(incr[1:0]), .inhibit(inhibit[1:0]), .load_en(load_en_c),
    .load_cnt(load_cnt_c), .load_seg(load_seg_c), .load_data(load_data_c),
    .count(c_count), .count_vld(c_vld), .ovf(c_ovf));

  // B: counters removed
  kronos_counter_bank #(.EN_COUNTERS(0), .WIDTH(64), .SEG_W(32), .NCNT(2)) u_b (
    .clk(clk), .rst(rst), .incr(incr[1:0]), .inhibit(inhibit[1:0]), .load_en(load_en),
    .load_cnt(load_cnt[0]), .load_seg(load_seg[0]), .load_data({load_data, load_data}),
    .count(b_count), .count_vld(b_vld), .ovf(b_ovf));

  // Reference model: segment values plus "segment k owes one count" flags.
  longint mseg [2][3][3];
  bit     mowe [2][3][3];
  bit     movf [2][3];

  function automatic int nseg_of(int d); return (d == 0) ? 3 : 1;  endfunction
  function automatic int segw_of(int d); return (d == 0) ? 16 : 8; endfunction
  function automatic int ncnt_of(int d); return (d == 0) ? 3 : 2;  endfunction

  task automatic model_step(int d, bit r, bit [2:0] inc, bit [2:0] inh,
                            bit le, int lc, int ls, longint ld);
    longint mx;
    bit     no [3];
    bit     nov;
    bit     bump;
    mx = (longint'(1) << segw_of(d)) - 1;
    for (int ch = 0; ch < ncnt_of(d); ch++) begin
      if (r) begin
        for (int k = 0; k < 3; k++) begin mseg[d][ch][k] = 0; mowe[d][ch][k] = 0; end
        movf[d][ch] = 0;
      end else if (le && lc == ch && ls < nseg_of(d)) begin
        mseg[d][ch][ls] = ld & mx;
        for (int k = 0; k < 3; k++) mowe[d][ch][k] = 0;
        movf[d][ch] = 0;
      end else begin
        no  = '{default: 0};
        nov = 0;
        for (int k = 0; k < nseg_of(d); k++) begin
          bump = (k == 0) ? (inc[ch] && !inh[ch]) : mowe[d][ch][k];
          if (bump) begin
            if (mseg[d][ch][k] == mx) begin
              mseg[d][ch][k] = 0;
              if (k == nseg_of(d) - 1) nov = 1;
              else no[k+1] = 1;
            end else begin
              mseg[d][ch][k] = mseg[d][ch][k] + 1;
            end
          end
        end
        for (int k = 0; k < 3; k++) mowe[d][ch][k] = no[k];
        movf[d][ch] = nov;
      end
    end
  endtask

  typedef struct {
    logic [143:0] a_cnt;
    logic [2:0]   a_vld;
    logic [2:0]   a_ovf;
    logic [15:0]  c_cnt;
    logic [1:0]   c_vld;
    logic [1:0]   c_ovf;
  } exp_t;

  exp_t sbq [$];
  exp_t mon_e;

  task automatic chk(string nm, logic [143:0] act, logic [143:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Apply current inputs for one clock; expected response is queued after the edge.
  task automatic tick();
    exp_t e;
    model_step(0, rst, incr, inhibit, load_en, int'(load_cnt), int'(load_seg), longint'(load_data));
    model_step(1, rst, {1'b0, incr[1:0]}, {1'b0, inhibit[1:0]}, load_en_c,
               int'(load_cnt_c), int'(load_seg_c), longint'(load_data_c));
    e.a_cnt = '0; e.a_vld = '0; e.a_ovf = '0; e.c_cnt = '0; e.c_vld = '0; e.c_ovf = '0;
    for (int ch = 0; ch < 3; ch++) begin
      for (int k = 0; k < 3; k++) e.a_cnt[ch*48 + k*16 +: 16] = mseg[0][ch][k][15:0];
      e.a_vld[ch] = !(mowe[0][ch][1] || mowe[0][ch][2]);
      e.a_ovf[ch] = movf[0][ch];
    end
    for (int ch = 0; ch < 2; ch++) begin
      e.c_cnt[ch*8 +: 8] = mseg[1][ch][0][7:0];
      e.c_vld[ch] = 1'b1;
      e.c_ovf[ch] = movf[1][ch];
    end
    @(posedge clk);
    sbq.push_back(e);
    #1;
  endtask

  task automatic load_a(int c, int s, int d);
    load_en = 1'b1; load_cnt = 2'(c); load_seg = 2'(s); load_data = 16'(d);
    tick();
    load_en = 1'b0;
  endtask

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      mon_e = sbq.pop_front();
      chk("a_count", a_count, mon_e.a_cnt);
      chk("a_vld_ovf", 144'({a_vld, a_ovf}), 144'({mon_e.a_vld, mon_e.a_ovf}));
      chk("c_count", 144'(c_count), 144'(mon_e.c_cnt));
      chk("c_vld_ovf", 144'({c_vld, c_ovf}), 144'({mon_e.c_vld, mon_e.c_ovf}));
      chk("b_tied", 144'({b_count, b_vld, b_ovf}), 144'({128'h0, 2'b11, 2'b00}));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset and idle
    rst = 1'b1; tick(); tick();
    rst = 1'b0; tick();
    chk("reset_count", a_count, 144'h0);
    chk("reset_flags", 144'({a_vld, a_ovf}), 144'({3'b111, 3'b000}));

    incr = 3'b001;
    repeat (5) tick();
    incr = 3'b000;
    chk("five_incr", a_count, 144'd5);

    // Two-stage carry
    load_a(0, 0, 16'hFFFF); load_a(0, 1, 16'h0007); load_a(0, 2, 0);
    incr = 3'b001; tick(); incr = 3'b000;
    chk("carry_pending", 144'({a_count[47:0], a_vld[0]}), 144'({48'h0000_0007_0000, 1'b0}));
    tick();
    chk("carry_settled", 144'({a_count[47:0], a_vld[0]}), 144'({48'h0000_0008_0000, 1'b1}));

    // Full ripple and overflow
    load_a(0, 0, 16'hFFFF); load_a(0, 1, 16'hFFFF); load_a(0, 2, 16'hFFFF);
    incr = 3'b001; tick(); incr = 3'b000;
    chk("ripple1", 144'({a_count[47:0], a_vld[0], a_ovf[0]}), 144'({48'hFFFF_FFFF_0000, 2'b00}));
    tick();
    chk("ripple2", 144'({a_count[47:0], a_vld[0], a_ovf[0]}), 144'({48'hFFFF_0000_0000, 2'b00}));
    tick();
    chk("ovf_pulse", 144'({a_count[47:0], a_vld[0], a_ovf[0]}), 144'({48'h0, 2'b11}));
    tick();
    chk("ovf_clear", 144'(a_ovf[0]), 144'(0));

    // Load discards an in-flight carry
    load_a(0, 0, 16'hFFFF); load_a(0, 1, 0); load_a(0, 2, 0);
    incr = 3'b001; tick(); incr = 3'b000;
    load_a(0, 0, 16'h0010);
    tick();
    chk("load_kills_carry", 144'({a_count[47:0], a_vld[0]}), 144'({48'h10, 1'b1}));

    // Inhibit and channel isolation
    rst = 1'b1; tick(); rst = 1'b0;
    incr = 3'b011; inhibit = 3'b010;
    for (int i = 0; i < 10; i++) begin
      if (i == 5) load_a(1, 0, 16'h1234);
      else tick();
    end
    incr = 3'b000; inhibit = 3'b000;
    chk("inhibit_iso", a_count, {48'h0, 48'h1234, 48'd10});

    // Out-of-range writes are ignored
    load_a(3, 0, 16'hABCD);
    load_a(0, 3, 16'hABCD);
    chk("out_of_range", a_count, {48'h0, 48'h1234, 48'd10});

    // Randomized phase
    for (int i = 0; i < 3000; i++) begin
      rst         = ($urandom_range(0, 399) == 0);
      incr        = 3'($urandom);
      inhibit     = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
      load_en     = ($urandom_range(0, 5) == 0);
      load_cnt    = 2'($urandom);
      load_seg    = 2'($urandom);
      load_data   = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(16'hFFFD, 16'hFFFF)) : 16'($urandom);
      load_en_c   = ($urandom_range(0, 7) == 0);
      load_cnt_c  = 1'($urandom);
      load_seg_c  = ($urandom_range(0, 3) == 0);
      load_data_c = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(8'hFD, 8'hFF)) : 8'($urandom);
      tick();
    end
    rst = 1'b0; incr = '0; inhibit = '0; load_en = 1'b0; load_en_c = 1'b0;
    tick();
    @(negedge clk); #1;
    n_tests++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
